// File: rtl/react_timer.sv
// react_timer: reaction-time meter core feeding a 4-digit 7-segment driver.
// After a start press it waits MIN_DELAY_MS + lfsr[10:0] ms, lights the
// stimulus LED, then counts elapsed ms in BCD until the react press.
// Optional macro DEBOUNCE_EN inserts a DEB_MS counter filter on both buttons.
module react_timer #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_DIV     = CLK_HZ / 1000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DEB_MS       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_react,
  output logic        led,
  output logic [15:0] dat,
  output logic        busy,
  output logic        err_fs,
  output logic        err_to
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + 2049);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DELAY_BASE = DW'(MIN_DELAY_MS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2} state_t;

  // BCD increment: each digit wraps 9 -> 0 and carries into the next
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        c = 1'b0;
      end
    end
    return r;
  endfunction

  logic [1:0]    r_st_sync, r_rc_sync;
  logic          w_st_lvl, w_rc_lvl;
  logic          r_st_dly, r_rc_dly;
  logic          r_st_press, r_rc_press;
  logic [15:0]   r_lfsr;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [DW-1:0] r_delay;
  state_t        r_state;
  logic          r_led, r_busy, r_err_fs, r_err_to;
  logic [15:0]   r_dat;

  // two-flop synchronisers for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_sync <= 2'b00;
      r_rc_sync <= 2'b00;
    end else begin
      r_st_sync <= {r_st_sync[0], btn_start};
      r_rc_sync <= {r_rc_sync[0], btn_react};
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DBW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEB_MS - 1);

  logic [TW-1:0]  r_ms_cnt;
  logic           w_ms_tick;
  logic           r_st_filt, r_rc_filt;
  logic [DBW-1:0] r_st_deb, r_rc_deb;

  assign w_ms_tick = (r_ms_cnt == TICK_LAST);

  // free-running ms prescaler pacing the debounce filters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ms_cnt <= '0;
    end else begin
      r_ms_cnt <= w_ms_tick ? '0 : r_ms_cnt + TW'(1);
    end
  end

  // filtered level follows raw level only after DEB_MS consecutive differing ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_filt <= 1'b0;
      r_rc_filt <= 1'b0;
      r_st_deb  <= '0;
      r_rc_deb  <= '0;
    end else begin
      if (r_st_sync[1] == r_st_filt) begin
        r_st_deb <= '0;
      end else if (w_ms_tick) begin
        if (r_st_deb == DEB_LAST) begin
          r_st_filt <= r_st_sync[1];
          r_st_deb  <= '0;
        end else begin
          r_st_deb <= r_st_deb + DBW'(1);
        end
      end
      if (r_rc_sync[1] == r_rc_filt) begin
        r_rc_deb <= '0;
      end else if (w_ms_tick) begin
        if (r_rc_deb == DEB_LAST) begin
          r_rc_filt <= r_rc_sync[1];
          r_rc_deb  <= '0;
        end else begin
          r_rc_deb <= r_rc_deb + DBW'(1);
        end
      end
    end
  end

  assign w_st_lvl = r_st_filt;
  assign w_rc_lvl = r_rc_filt;
`else
  assign w_st_lvl = r_st_sync[1];
  assign w_rc_lvl = r_rc_sync[1];

  // DEB_MS only shapes the filtered build; keep a zero-length setting out of it
  if (DEB_MS < 1) begin : g_deb_ms_unused
  end
`endif

  // rising-edge detect: one-cycle registered press pulse per button
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_dly   <= 1'b0;
      r_rc_dly   <= 1'b0;
      r_st_press <= 1'b0;
      r_rc_press <= 1'b0;
    end else begin
      r_st_dly   <= w_st_lvl;
      r_rc_dly   <= w_rc_lvl;
      r_st_press <= w_st_lvl & ~r_st_dly;
      r_rc_press <= w_rc_lvl & ~r_rc_dly;
    end
  end

  // 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every clock
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // main FSM with ms tick counter (restarted on every state entry)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_delay    <= '0;
      r_dat      <= 16'h0000;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_err_fs   <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (r_st_press) begin
        // start (or re-arm) has priority over everything else
        r_state    <= S_WAIT;
        r_tick_cnt <= '0;
        r_delay    <= DELAY_BASE + DW'(r_lfsr[10:0]);
        r_err_fs   <= 1'b0;
        r_err_to   <= 1'b0;
        r_led      <= 1'b0;
        r_busy     <= 1'b1;
        if (r_state != S_IDLE) begin
          r_dat <= 16'h0000;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_led  <= 1'b0;
            r_busy <= 1'b0;
          end
          S_WAIT: begin
            if (r_rc_press) begin
              r_state    <= S_IDLE;
              r_tick_cnt <= '0;
              r_dat      <= 16'hEEEE;
              r_err_fs   <= 1'b1;
              r_busy     <= 1'b0;
            end else if (w_tick) begin
              r_delay <= r_delay - DW'(1);
              if (r_delay == DW'(1)) begin
                r_state    <= S_RUN;
                r_tick_cnt <= '0;
                r_dat      <= 16'h0000;
                r_led      <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (r_rc_press) begin
              // freeze the pre-tick value even if a tick lands this cycle
              r_state    <= S_IDLE;
              r_tick_cnt <= '0;
              r_led      <= 1'b0;
              r_busy     <= 1'b0;
            end else if (w_tick) begin
              if (r_dat == 16'h9999) begin
                r_state    <= S_IDLE;
                r_tick_cnt <= '0;
                r_err_to   <= 1'b1;
                r_led      <= 1'b0;
                r_busy     <= 1'b0;
              end else begin
                r_dat <= bcd_inc(r_dat);
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign led    = r_led;
  assign dat    = r_dat;
  assign busy   = r_busy;
  assign err_fs = r_err_fs;
  assign err_to = r_err_to;

endmodule

// File: tb/tb_react_timer.sv
// Scoreboard bench for react_timer: stimulus pushes expected LED-rise cycles
// and end-of-measurement results; a negedge monitor pops and compares them.
// A scaled clock (2 cycles per ms, 4 ms minimum wait) keeps runs short.
module tb_react_timer;
  localparam int CLK_HZ = 2000;
  localparam int TD     = CLK_HZ / 1000;
  localparam int MIN_MS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start;
  logic        btn_react;
  logic        led;
  logic [15:0] dat;
  logic        busy;
  logic        err_fs;
  logic        err_to;

  react_timer #(.CLK_HZ(CLK_HZ), .MIN_DELAY_MS(MIN_MS), .DEB_MS(10)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_react(btn_react),
    .led(led), .dat(dat), .busy(busy), .err_fs(err_fs), .err_to(err_to)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int rst_edge = 0;

  typedef struct {
    int          end_cyc;
    logic [15:0] dat;
    logic        fs;
    logic        to;
  } res_t;

  res_t res_q[$];
  int   led_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // LFSR content after edge n, stepping the specified polynomial from reset
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = rst_edge; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // monitor: compare whenever LED rises or a measurement ends (busy falls)
  logic prev_led = 1'b0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_led === 1'b0 && led === 1'b1) begin
        if (led_q.size() == 0) begin
          check("unexpected_led_rise", 32'd1, 32'd0);
        end else begin
          check("led_rise_cycle", cyc, led_q[0]);
          void'(led_q.pop_front());
        end
      end
      if (prev_busy === 1'b1 && busy === 1'b0) begin
        if (res_q.size() == 0) begin
          check("unexpected_end", 32'd1, 32'd0);
        end else begin
          check("end_cycle", cyc, res_q[0].end_cyc);
          check("dat", dat, res_q[0].dat);
          check("err_fs", err_fs, res_q[0].fs);
          check("err_to", err_to, res_q[0].to);
          check("led_off", led, 1'b0);
          void'(res_q.pop_front());
        end
      end
    end
    prev_led  <= led;
    prev_busy <= busy;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: no finish by cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // press start (optionally react too) now; returns entry edge and delay in ms
  task automatic start_at(input bit with_react, output int ew, output int d);
    int c;
    c = cyc;
    btn_start = 1'b1;
    btn_react = with_react;
    @(negedge clk);
    btn_start = 1'b0;
    btn_react = 1'b0;
    ew = c + 4;
    d  = MIN_MS + int'(lfsr_after(c + 3) & 16'h07FF);
  endtask

  task automatic entry_check(input int ew);
    wait_to(ew);
    check("entry_busy", busy, 1'b1);
    check("entry_led", led, 1'b0);
    check("entry_err_fs", err_fs, 1'b0);
    check("entry_err_to", err_to, 1'b0);
  endtask

  // react press that takes effect at edge ea
  task automatic react_at(input int ea);
    wait_to(ea - 4);
    btn_react = 1'b1;
    @(negedge clk);
    btn_react = 1'b0;
  endtask

  task automatic push_res(input int e, input logic [15:0] v, input logic fs, input logic to);
    res_t r;
    r.end_cyc = e; r.dat = v; r.fs = fs; r.to = to;
    res_q.push_back(r);
  endtask

  task automatic reset_check();
    check("rst_dat", dat, 16'h0000);
    check("rst_led", led, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_fs", err_fs, 1'b0);
    check("rst_err_to", err_to, 1'b0);
  endtask

  // normal measurement: react takes effect m cycles after LED on
  task automatic do_normal(input int m);
    int ew, d, eled, ea;
    start_at(1'b0, ew, d);
    entry_check(ew);
    eled = ew + d * TD;
    led_q.push_back(eled);
    ea = eled + m;
    push_res(ea, to_bcd((m - 1) / TD), 1'b0, 1'b0);
    react_at(ea);
    wait_to(ea + 3);
  endtask

  // false start m cycles after entering WAIT (m=0: exactly at expiry)
  task automatic do_fs(input int m0);
    int ew, d, ea;
    start_at(1'b0, ew, d);
    entry_check(ew);
    ea = ew + ((m0 == 0) ? d * TD : m0);
    push_res(ea, 16'hEEEE, 1'b1, 1'b0);
    react_at(ea);
    wait_to(ea + 3);
  endtask

  task automatic do_timeout();
    int ew, d, eled;
    start_at(1'b0, ew, d);
    entry_check(ew);
    eled = ew + d * TD;
    led_q.push_back(eled);
    push_res(eled + 10000 * TD, 16'h9999, 1'b0, 1'b1);
    wait_to(eled + 10000 * TD + 3);
  endtask

  // re-arm at dat=0042 with a simultaneous react, then react on a tick edge
  task automatic do_rearm();
    int ew, d, eled, eb, ew2, d2, eled2, ea;
    start_at(1'b0, ew, d);
    entry_check(ew);
    eled = ew + d * TD;
    led_q.push_back(eled);
    eb = eled + 42 * TD + 1;
    wait_to(eb - 4);
    start_at(1'b1, ew2, d2);
    wait_to(eb - 1);
    check("run_dat_0042", dat, 16'h0042);
    entry_check(ew2);
    check("rearm_dat", dat, 16'h0000);
    eled2 = ew2 + d2 * TD;
    led_q.push_back(eled2);
    ea = eled2 + 7 * TD;
    push_res(ea, 16'h0006, 1'b0, 1'b0);
    react_at(ea);
    wait_to(ea + 3);
  endtask

  initial begin
    int ew, d;
    rst = 1'b1;
    btn_start = 1'b0;
    btn_react = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_edge = cyc;
    rst = 1'b0;
    reset_check();
    @(negedge clk);

    do_normal(1234 * TD + 1);
    do_fs(50 * TD);
    do_fs(0);
    do_timeout();
    do_rearm();
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) do_normal(int'($urandom_range(1, 300)));
      else do_fs(int'($urandom_range(4, 200)));
      repeat (int'($urandom_range(1, 5))) @(negedge clk);
    end

    // reset in the middle of WAIT
    start_at(1'b0, ew, d);
    entry_check(ew);
    wait_to(ew + 20);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_check();

    repeat (5) @(negedge clk);
    check("result_queue_drained", res_q.size(), 32'd0);
    check("led_queue_drained", led_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
